// File: rtl/axi_lite_master_ctrl_if.sv
// rtl/axi_lite_master_ctrl_if.sv - AXI4-Lite bus bundle between the command master and a register slave
interface axi_lite_master_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_master_ctrl.sv
// rtl/axi_lite_master_ctrl.sv - single-beat AXI4-Lite master with independent AW/W and response timeout
module axi_lite_master_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int TO_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    input  logic [DATA_W/8-1:0]    cmd_wstrb,
    output logic                   done,
    output logic [DATA_W-1:0]      done_rdata,
    output logic [1:0]             done_resp,
    output logic                   done_timeout,
    axi_lite_master_ctrl_if.master m_axi_lite
);

    // Timeout fires when the counter would reach 2^TO_W-1, i.e. after that many
    // response-phase cycles without bvalid/rvalid. TO_W must be at least 2.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((2 ** TO_W) - 2);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_WR_REQ  = 6'b000010,
        S_WR_RESP = 6'b000100,
        S_RD_ADDR = 6'b001000,
        S_RD_DATA = 6'b010000,
        S_DONE    = 6'b100000
    } state_t;

    state_t                state;
    logic [TO_W-1:0]       to_cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  aw_clear;
    logic                  w_clear;

    assign m_axi_lite.awaddr  = addr_q;
    assign m_axi_lite.araddr  = addr_q;
    assign m_axi_lite.wdata   = wdata_q;
    assign m_axi_lite.wstrb   = wstrb_q;
    assign m_axi_lite.awvalid = awvalid_q;
    assign m_axi_lite.wvalid  = wvalid_q;
    assign m_axi_lite.bready  = bready_q;
    assign m_axi_lite.arvalid = arvalid_q;
    assign m_axi_lite.rready  = rready_q;

    // A channel counts as finished once its valid has already dropped or it handshakes now.
    assign aw_clear = !awvalid_q || m_axi_lite.awready;
    assign w_clear  = !wvalid_q  || m_axi_lite.wready;

    // Transaction sequencer; every bus and status output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b0;
            to_cnt       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            done         <= 1'b0;
            done_rdata   <= '0;
            done_resp    <= 2'b00;
            done_timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= S_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (awvalid_q && m_axi_lite.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi_lite.wready)   wvalid_q  <= 1'b0;
                    if (aw_clear && w_clear) begin
                        bready_q <= 1'b1;
                        to_cnt   <= '0;
                        state    <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi_lite.bvalid) begin
                        bready_q     <= 1'b0;
                        done_resp    <= m_axi_lite.bresp;
                        done_timeout <= 1'b0;
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        bready_q     <= 1'b0;
                        done_resp    <= 2'b10;
                        done_timeout <= 1'b1;
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                S_RD_ADDR: begin
                    if (m_axi_lite.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        to_cnt    <= '0;
                        state     <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi_lite.rvalid) begin
                        rready_q     <= 1'b0;
                        done_rdata   <= m_axi_lite.rdata;
                        done_resp    <= m_axi_lite.rresp;
                        done_timeout <= 1'b0;
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        rready_q     <= 1'b0;
                        done_resp    <= 2'b10;
                        done_timeout <= 1'b1;
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_lite_master_ctrl.md
# axi_lite_master_ctrl

Parametrised AXI4-Lite master that turns single-beat register commands from the DMA control logic into complete AXI4-Lite write or read transactions. It supersedes the write-only lite controller: it adds reads, write strobes, independent AW/W handshaking, response capture and a response timeout. It sits between the descriptor/config sequencer and the DMA core's AXI-Lite register slave.

## Interface
- ADDR_W, 10, address width
- DATA_W, 32, data width (multiple of 8)
- TO_W, 8, timeout counter width; timeout limit = 2^TO_W-1 cycles
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  byte strobes (ignored for reads)
- done  out  1  one-cycle completion pulse
- done_rdata  out  DATA_W  read data (held until next done)
- done_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- done_timeout  out  1  set with done when response timed out
- m_axi_lite_awaddr/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp/bvalid in, bready out; araddr/arvalid out, arready in; rdata/rresp/rvalid in, rready out. Widths per ADDR_W/DATA_W, resp 2, handshakes 1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE (one-hot).
- IDLE: cmd_ready=1. On accept, latch addr/wdata/wstrb into output registers; go WR_REQ (write) or RD_ADDR (read).
- WR_REQ: awvalid and wvalid both rise on entry. Each drops independently on its own handshake (awvalid&awready, wvalid&wready), and never drops before that. AW and W may complete in either order or the same cycle. When both have completed, go WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp and go DONE.
- RD_ADDR: arvalid=1 until arready, then RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata/rresp and go DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timeout: the counter clears on entry to WR_RESP/RD_DATA and increments each cycle without bvalid/rvalid. At limit: drop bready/rready, set done_resp=2'b10 and done_timeout=1, go DONE. A late B/R after a timeout is a fatal system fault and requires rst. The AW/W/AR phases never time out, since AXI forbids withdrawing valid.
- done_resp and done_rdata hold until the next DONE. done_rdata is unchanged by writes.
- Unknown/illegal state: go IDLE.

## Timing
- Reset: state IDLE. All valid/ready outputs 0, done 0, done_timeout 0, done_resp 0, done_rdata 0, address/data/strb outputs 0. cmd_ready is 0 during rst and 1 the cycle after rst deasserts.
- Accept at cycle T: valids high at T+1.
- Best-case write (awready, wready and bvalid all high): the handshake completes at T+1, bready is high at T+2, done is at T+3, and cmd_ready is 1 at T+4.
- Best-case read: same latency, with AR in place of AW/W.
- Throughput: one command per 4 cycles minimum. cmd_ready is low from T+1 until return to IDLE.
- rst mid-transaction: all valids/readies drop on the next edge. No done is issued.

## Test plan
- Write 0x0A5 <= 0xDEADBEEF, strb 4'hF, slave always ready, bresp 0: awaddr=0x0A5 and wdata=0xDEADBEEF at T+1, done at T+3 with resp 0, done_timeout 0.
- Write with awready delayed 3 cycles and wready immediate: wvalid drops after 1 cycle, awvalid stays high 4 cycles, bready rises only after both complete, resp passes through unchanged.
- Read 0x010, arready after 2 cycles, rvalid after 5 with rdata 0x12345678 and rresp 2'b01: done_rdata=0x12345678, done_resp=1.
- Write with no bvalid (TO_W=4): done exactly 15 cycles after WR_RESP entry, done_resp=2'b10, done_timeout=1, bready low at done.
- Back-to-back commands held valid: second accept 4 cycles after the first, no valid asserted in DONE/IDLE gaps.
- rst asserted while in WR_REQ with awvalid high: next cycle all valids are 0, state is IDLE, and no done pulse is issued.
